// File: rtl/nibble_sequencer_if.sv
// Word-in / nibble-out stream bundle for the nibble sequencer.
// The master view is the sequencer itself, and the slave view is its environment.
interface nibble_sequencer_if #(
  parameter int CNT_W = 8
);
  logic [15:0]      in_word;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      mux_in;
  logic [1:0]       mux_sel;
  logic             nib_valid;
  logic             nib_last;
  logic             nib_ready;
  logic [CNT_W-1:0] word_count;

  modport master (
    input  in_word,
    input  in_valid,
    output in_ready,
    output mux_in,
    output mux_sel,
    output nib_valid,
    output nib_last,
    input  nib_ready,
    output word_count
  );

  modport slave (
    output in_word,
    output in_valid,
    input  in_ready,
    input  mux_in,
    input  mux_sel,
    input  nib_valid,
    input  nib_last,
    output nib_ready,
    input  word_count
  );
endinterface

// File: rtl/nibble_sequencer.sv
// Holds a 16-bit word on the mux input and walks the nibble select.
// Words can follow each other back to back when the source keeps valid high.
module nibble_sequencer #(
  parameter bit MSB_FIRST = 1'b0,
  parameter int CNT_W     = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  nibble_sequencer_if.master  bus
);

  localparam logic [1:0] FIRST = MSB_FIRST ? 2'd3 : 2'd0;
  localparam logic [1:0] LAST  = MSB_FIRST ? 2'd0 : 2'd3;
  localparam logic [1:0] STEP  = MSB_FIRST ? 2'd3 : 2'd1;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [15:0]      word_q;
  logic [15:0]      word_d;
  logic [1:0]       sel_q;
  logic [1:0]       sel_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             valid;
  logic             last;
  logic             xfer;
  logic             ready;
  logic             load;

  // State, held word, select and completed-word count registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      sel_q   <= FIRST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake decode and next-state selection
  always_comb begin
    valid   = (state_q == SEND);
    last    = valid && (sel_q == LAST);
    xfer    = valid && bus.nib_ready;
    ready   = rst_n && (!valid || (last && bus.nib_ready));
    load    = bus.in_valid && ready;
    state_d = state_q;
    word_d  = word_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          word_d  = bus.in_word;
          sel_d   = FIRST;
          state_d = SEND;
        end
      end
      SEND: begin
        if (xfer && !last) begin
          sel_d = sel_q + STEP;
        end else if (xfer) begin
          cnt_d = cnt_q + CNT_W'(1);
          sel_d = FIRST;
          if (load) begin
            word_d = bus.in_word;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready   = ready;
  assign bus.mux_in     = word_q;
  assign bus.mux_sel    = sel_q;
  assign bus.nib_valid  = valid;
  assign bus.nib_last   = last;
  assign bus.word_count = cnt_q;

endmodule
